// File: rtl/md_unit_if.sv
// md_unit_if: EX-stage to multiply/divide unit bundle
//   start/md_func/md_sign - accepted operation request and its decoded MD control
//   rs_val/rt_val         - forwarded operands
//   cancel                - flush kill of the request or in-flight operation
//   busy/hi/lo            - unit status and architectural HI/LO
interface md_unit_if;
    logic        start;
    logic [2:0]  md_func;
    logic        md_sign;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, md_func, md_sign, rs_val, rt_val, cancel, input busy, hi, lo);
    modport slave (input start, md_func, md_sign, rs_val, rt_val, cancel, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/div unit owning the architectural HI/LO registers
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - md_unit_if.slave: start/md_func/md_sign/rs_val/rt_val/cancel in, busy/hi/lo out
module md_unit #(
    parameter int MUL_LAT = 5
) (
    input logic      clk,
    input logic      reset,
    md_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t      state, next_state;
    logic [5:0]  cnt;
    logic [31:0] op_a, op_b, rem, hi_q, lo_q, rs_mag, rt_mag;
    logic        md_signed, q_neg, r_neg, accept, done, ge;
    logic [32:0] shifted;
    logic [63:0] prod;
    assign bus.busy = state != IDLE;
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
    always_comb begin
        rs_mag = (bus.md_sign && bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
        rt_mag = (bus.md_sign && bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;
        // sign extension to 64 bits makes one unsigned multiplier serve both signednesses
        prod = {{32{md_signed & op_a[31]}}, op_a} * {{32{md_signed & op_b[31]}}, op_b};
        // op_a doubles as the dividend shift register that fills with quotient bits
        shifted = {rem, op_a[31]};
        ge = shifted >= {1'b0, op_b};
    end
    always_comb begin
        next_state = state;
        accept = 1'b0;
        done = 1'b0;
        if (state == IDLE) begin
            accept = bus.start && !bus.cancel;
            next_state = !accept ? IDLE : bus.md_func == 3'd3 ? MUL : bus.md_func == 3'd4 ? DIV : IDLE;
        end else begin
            done = !bus.cancel && cnt == 6'd0;
            next_state = (bus.cancel || done) ? IDLE : state;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            op_a <= '0;
            op_b <= '0;
            rem <= '0;
            hi_q <= '0;
            lo_q <= '0;
            md_signed <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                if (bus.md_func == 3'd1) hi_q <= bus.rs_val;
                if (bus.md_func == 3'd2) lo_q <= bus.rs_val;
                if (bus.md_func == 3'd3) begin
                    op_a <= bus.rs_val;
                    op_b <= bus.rt_val;
                    md_signed <= bus.md_sign;
                    cnt <= 6'(MUL_LAT - 1);
                end
                if (bus.md_func == 3'd4) begin
                    op_a <= rs_mag;
                    op_b <= rt_mag;
                    rem <= '0;
                    q_neg <= bus.md_sign & (bus.rs_val[31] ^ bus.rt_val[31]);
                    r_neg <= bus.md_sign & bus.rs_val[31];
                    cnt <= 6'd32;
                end
            end else if (state != IDLE && !bus.cancel && cnt != 6'd0) begin
                cnt <= cnt - 6'd1;
                if (state == DIV) begin
                    rem <= ge ? 32'(shifted - {1'b0, op_b}) : shifted[31:0];
                    op_a <= {op_a[30:0], ge};
                end
            end
            if (done) begin
                hi_q <= state == MUL ? prod[63:32] : r_neg ? -rem : rem;
                lo_q <= state == MUL ? prod[31:0] : q_neg ? -op_a : op_a;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (MUL_LAT 5, plus 1 and 8 instances)
module tb_md_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int passed = 0;
    int total = 0;
    md_unit_if m();
    md_unit_if i1();
    md_unit_if i8();
    always #5 clk = ~clk;
    assign i1.start = m.start;
    assign i1.md_func = m.md_func;
    assign i1.md_sign = m.md_sign;
    assign i1.rs_val = m.rs_val;
    assign i1.rt_val = m.rt_val;
    assign i1.cancel = m.cancel;
    assign i8.start = m.start;
    assign i8.md_func = m.md_func;
    assign i8.md_sign = m.md_sign;
    assign i8.rs_val = m.rs_val;
    assign i8.rt_val = m.rt_val;
    assign i8.cancel = m.cancel;
    md_unit #(.MUL_LAT(5)) dut (.clk(clk), .reset(reset), .bus(m.slave));
    md_unit #(.MUL_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(i1.slave));
    md_unit #(.MUL_LAT(8)) dut8 (.clk(clk), .reset(reset), .bus(i8.slave));
    always @(posedge clk) assert (!(m.start && m.busy)) else $error("start issued while busy");
    task automatic issue(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        m.start = 1'b1;
        m.md_func = f;
        m.md_sign = s;
        m.rs_val = a;
        m.rt_val = b;
        @(posedge clk);
        #1;
        m.start = 1'b0;
        m.md_func = 3'd0;
    endtask
    task automatic wait_idle(output int n);
        n = 0;
        while (m.busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask
    task automatic test_reset;
        #2;
        total++; if (m.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", m.busy); else passed++;
        total++; if (m.hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", m.hi); else passed++;
        total++; if (m.lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", m.lo); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask
    task automatic test_mult;
        int n;
        issue(3'd3, 1'b1, 32'hFFFF_FFFD, 32'd7);
        wait_idle(n);
        total++; if (n !== 5) $display("FAIL mult_latency: got %0d want 5", n); else passed++;
        total++; if (m.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", m.hi); else passed++;
        total++; if (m.lo !== 32'hFFFF_FFEB) $display("FAIL mult_lo: got %h want ffffffeb", m.lo); else passed++;
        repeat (10) @(posedge clk);
    endtask
    task automatic test_multu_latency;
        int n5 = -1, n1 = -1, n8 = -1;
        issue(3'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (!m.busy && n5 < 0) n5 = e;
            if (!i1.busy && n1 < 0) n1 = e;
            if (!i8.busy && n8 < 0) n8 = e;
        end
        total++; if (n5 !== 5) $display("FAIL multu_lat5: got %0d want 5", n5); else passed++;
        total++; if (n1 !== 1) $display("FAIL multu_lat1: got %0d want 1", n1); else passed++;
        total++; if (n8 !== 8) $display("FAIL multu_lat8: got %0d want 8", n8); else passed++;
        total++; if ({m.hi, m.lo} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_res5: got %h want fffffffe00000001", {m.hi, m.lo}); else passed++;
        total++; if ({i1.hi, i1.lo} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_res1: got %h want fffffffe00000001", {i1.hi, i1.lo}); else passed++;
        total++; if ({i8.hi, i8.lo} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_res8: got %h want fffffffe00000001", {i8.hi, i8.lo}); else passed++;
    endtask
    task automatic test_div;
        int n;
        issue(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        total++; if (n !== 33) $display("FAIL div_latency: got %0d want 33", n); else passed++;
        total++; if (m.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h want fffffffd", m.lo); else passed++;
        total++; if (m.hi !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h want ffffffff", m.hi); else passed++;
        issue(3'd4, 1'b0, 32'd100, 32'd7);
        wait_idle(n);
        total++; if (m.lo !== 32'd14) $display("FAIL divu_lo: got %h want 0000000e", m.lo); else passed++;
        total++; if (m.hi !== 32'd2) $display("FAIL divu_hi: got %h want 00000002", m.hi); else passed++;
    endtask
    task automatic test_div_edge;
        int n;
        issue(3'd4, 1'b0, 32'h1234_5678, 32'd0);
        wait_idle(n);
        total++; if (m.lo !== 32'hFFFF_FFFF) $display("FAIL divu0_lo: got %h want ffffffff", m.lo); else passed++;
        total++; if (m.hi !== 32'h1234_5678) $display("FAIL divu0_hi: got %h want 12345678", m.hi); else passed++;
        issue(3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        total++; if (m.lo !== 32'h8000_0000) $display("FAIL divovf_lo: got %h want 80000000", m.lo); else passed++;
        total++; if (m.hi !== 32'h0) $display("FAIL divovf_hi: got %h want 00000000", m.hi); else passed++;
    endtask
    task automatic test_mthi_mtlo;
        logic [31:0] lo0;
        lo0 = m.lo;
        issue(3'd1, 1'b0, 32'hAAAA_0000, 32'd0);
        total++; if (m.busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", m.busy); else passed++;
        total++; if (m.hi !== 32'hAAAA_0000) $display("FAIL mthi_hi: got %h want aaaa0000", m.hi); else passed++;
        total++; if (m.lo !== lo0) $display("FAIL mthi_lo_kept: got %h want %h", m.lo, lo0); else passed++;
        issue(3'd2, 1'b0, 32'h0000_5555, 32'd0);
        total++; if (m.busy !== 1'b0) $display("FAIL mtlo_busy: got %b want 0", m.busy); else passed++;
        total++; if (m.lo !== 32'h0000_5555) $display("FAIL mtlo_lo: got %h want 00005555", m.lo); else passed++;
        total++; if (m.hi !== 32'hAAAA_0000) $display("FAIL mtlo_hi_kept: got %h want aaaa0000", m.hi); else passed++;
        issue(3'd6, 1'b0, 32'hDEAD_BEEF, 32'd0);
        total++; if ({m.busy, m.hi, m.lo} !== {1'b0, 64'hAAAA_0000_0000_5555}) $display("FAIL func6_noop: got %h want aaaa000000005555", {m.hi, m.lo}); else passed++;
    endtask
    task automatic test_cancel;
        issue(3'd1, 1'b0, 32'd1, 32'd0);
        issue(3'd2, 1'b0, 32'd2, 32'd0);
        issue(3'd4, 1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        m.cancel = 1'b1;
        @(posedge clk);
        #1;
        m.cancel = 1'b0;
        total++; if (m.busy !== 1'b0) $display("FAIL cancel10_busy: got %b want 0", m.busy); else passed++;
        total++; if ({m.hi, m.lo} !== 64'h1_0000_0002) $display("FAIL cancel10_hilo: got %h want 0000000100000002", {m.hi, m.lo}); else passed++;
        issue(3'd4, 1'b0, 32'd1000, 32'd3);
        repeat (32) @(posedge clk);
        #1;
        total++; if (m.busy !== 1'b1) $display("FAIL cancel33_pre_busy: got %b want 1", m.busy); else passed++;
        @(negedge clk);
        m.cancel = 1'b1;
        @(posedge clk);
        #1;
        m.cancel = 1'b0;
        total++; if (m.busy !== 1'b0) $display("FAIL cancel33_busy: got %b want 0", m.busy); else passed++;
        total++; if ({m.hi, m.lo} !== 64'h1_0000_0002) $display("FAIL cancel33_hilo: got %h want 0000000100000002", {m.hi, m.lo}); else passed++;
        @(negedge clk);
        m.cancel = 1'b1;
        m.start = 1'b1;
        m.md_func = 3'd1;
        m.rs_val = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        m.md_func = 3'd3;
        @(posedge clk);
        #1;
        m.start = 1'b0;
        m.cancel = 1'b0;
        m.md_func = 3'd0;
        total++; if ({m.busy, m.hi, m.lo} !== {1'b0, 64'h1_0000_0002}) $display("FAIL cancel_idle: got busy=%b hilo=%h want busy=0 hilo=0000000100000002", m.busy, {m.hi, m.lo}); else passed++;
    endtask
    task automatic test_reset_mid_mult;
        issue(3'd3, 1'b0, 32'd3, 32'd3);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++; if (m.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", m.busy); else passed++;
        total++; if ({m.hi, m.lo} !== 64'h0) $display("FAIL rstmid_hilo: got %h want 0", {m.hi, m.lo}); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask
    task automatic test_back_to_back;
        int n;
        issue(3'd3, 1'b1, 32'hFFFF_FFFD, 32'd7);
        wait_idle(n);
        issue(3'd3, 1'b0, 32'd2, 32'd3);
        total++; if (m.busy !== 1'b1) $display("FAIL b2b_accept: got %b want 1", m.busy); else passed++;
        wait_idle(n);
        total++; if (n !== 5) $display("FAIL b2b_latency: got %0d want 5", n); else passed++;
        total++; if ({m.hi, m.lo} !== 64'd6) $display("FAIL b2b_res: got %h want 0000000000000006", {m.hi, m.lo}); else passed++;
    endtask
    initial begin
        m.start = 1'b0;
        m.md_func = 3'd0;
        m.md_sign = 1'b0;
        m.rs_val = 32'd0;
        m.rt_val = 32'd0;
        m.cancel = 1'b0;
        test_reset();
        test_mult();
        test_multu_latency();
        test_div();
        test_div_edge();
        test_mthi_mtlo();
        test_cancel();
        test_reset_mid_mult();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
